// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared RAM status and word types
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single RAM port arbiter between icache and dcache
// Data has priority; a streak counter forces an instruction grant after MAX_DSTREAK data grants.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] DMAX = SW'(MAX_DSTREAK);

  arb_state_t    state, next_state;
  logic [SW-1:0] dstreak, dstreak_next;
  ramstate_t     rs;
  logic          dreq;

  assign rs    = ramstate_t'(ramstate);
  assign dreq  = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      dstreak <= '0;
    end else begin
      state   <= next_state;
      dstreak <= dstreak_next;
    end
  end

  always_comb begin
    next_state   = state;
    dstreak_next = dstreak;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    grant        = 2'b00;
    iwait        = 1'b1;
    dwait        = 1'b1;
    unique case (state)
      IDLE: begin
        if (dreq && iREN && dstreak == DMAX) begin
          next_state   = SERVE_I;
          dstreak_next = '0;
        end else if (dreq) begin
          next_state   = SERVE_D;
          dstreak_next = !iREN ? '0 : (dstreak == DMAX) ? dstreak : dstreak + SW'(1);
        end else if (iREN) begin
          next_state   = SERVE_I;
          dstreak_next = '0;
        end
      end
      SERVE_I: begin
        grant   = 2'b01;
        ramREN  = iREN;
        ramaddr = iaddr;
        // A dropped request aborts silently; ERROR retries through IDLE re-arbitration.
        if (!iREN) begin
          next_state = IDLE;
        end else if (rs == ACCESS) begin
          iwait      = 1'b0;
          next_state = IDLE;
        end else if (rs == ERROR) begin
          next_state = IDLE;
        end
      end
      SERVE_D: begin
        grant    = 2'b10;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) begin
          next_state = IDLE;
        end else if (rs == ACCESS) begin
          dwait      = 1'b0;
          next_state = IDLE;
        end else if (rs == ERROR) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
